vx_ibuffer_scalar_queue: RTL and testbench

- Per-issue-slice instruction buffer feeding the scalar scoreboard; accepts decoded instructions from decode and holds them in one FIFO per warp slot (wis).
- Presents one instruction at a time through a registered output, picking round-robin among non-empty warps.
- Preserves order within each warp and reports per-warp dequeue pulses so the scheduler can release warps.

---
 rtl/vx_ibuffer_scalar_queue.sv | 161 ++++++++++++++++
 tb/tb_vx_ibuffer_scalar_queue.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_ibuffer_scalar_queue.sv
// Per-slice instruction buffer: one FIFO per warp slot, round-robin
// drain into a single registered output feeding the scalar scoreboard.
module vx_ibuffer_scalar_queue #(
  parameter int DATAW       = 128,
  parameter int ISSUE_RATIO = 4,
  parameter int DEPTH       = 2,
  parameter int WIS_W       = (ISSUE_RATIO > 1) ? $clog2(ISSUE_RATIO) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   decode_valid,
  input  logic [WIS_W-1:0]       decode_wis,
  input  logic [DATAW-1:0]       decode_data,
  output logic                   decode_ready,
  output logic                   ibuf_valid,
  output logic [WIS_W-1:0]       ibuf_wis,
  output logic [DATAW-1:0]       ibuf_data,
  input  logic                   ibuf_ready,
  output logic [ISSUE_RATIO-1:0] deq_mask,
  output logic [ISSUE_RATIO-1:0] empty_mask
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATAW-1:0] r_mem  [ISSUE_RATIO][DEPTH];
  logic [PTR_W-1:0] r_wptr [ISSUE_RATIO];
  logic [PTR_W-1:0] r_rptr [ISSUE_RATIO];
  logic [CNT_W-1:0] r_cnt  [ISSUE_RATIO];

  logic             r_valid;
  logic [WIS_W-1:0] r_wis;
  logic [DATAW-1:0] r_data;
  logic [WIS_W-1:0] r_rr;

  logic [ISSUE_RATIO-1:0] w_nonempty;
  logic [ISSUE_RATIO-1:0] w_full;
  logic [ISSUE_RATIO-1:0] w_push;
  logic [ISSUE_RATIO-1:0] w_pop;
  logic                   w_ready;
  logic                   w_any;
  logic                   w_load;
  logic                   w_found;
  logic [WIS_W-1:0]       w_grant;
  logic [WIS_W-1:0]       w_rr_next;
  logic [DATAW-1:0]       w_head;
  int                     w_occ;

  // Acceptance looks only at registered occupancy, never at this cycle's pop
  always_comb begin
    w_nonempty = '0;
    w_full     = '0;
    w_ready    = 1'b0;
    for (int w = 0; w < ISSUE_RATIO; w++) begin
      w_nonempty[w] = (r_cnt[w] != '0);
      w_full[w]     = (r_cnt[w] == CNT_W'(DEPTH));
      if (decode_wis == WIS_W'(w))
        w_ready = ~w_full[w];
    end
  end

  assign w_any  = |w_nonempty;
  assign w_load = (~r_valid | ibuf_ready) & w_any;

  always_comb begin
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_grant = '0;
    for (int i = 0; i < ISSUE_RATIO; i++) begin
      idx = (int'(r_rr) + i) % ISSUE_RATIO;
      if (!w_found && w_nonempty[idx]) begin
        w_found = 1'b1;
        w_grant = WIS_W'(idx);
      end
    end
  end

  assign w_rr_next = WIS_W'((int'(w_grant) + 1) % ISSUE_RATIO);
  assign w_head    = r_mem[w_grant][r_rptr[w_grant]];

  always_comb begin
    w_push = '0;
    w_pop  = '0;
    for (int w = 0; w < ISSUE_RATIO; w++) begin
      w_push[w] = decode_valid & w_ready
                & (decode_wis == WIS_W'(w));
      w_pop[w]  = w_load & (w_grant == WIS_W'(w));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int w = 0; w < ISSUE_RATIO; w++) begin
        r_wptr[w] <= '0;
        r_rptr[w] <= '0;
        r_cnt[w]  <= '0;
      end
    end else begin
      for (int w = 0; w < ISSUE_RATIO; w++) begin
        if (w_push[w])
          r_wptr[w] <= r_wptr[w] + PTR_W'(1);
        if (w_pop[w])
          r_rptr[w] <= r_rptr[w] + PTR_W'(1);
        r_cnt[w] <= r_cnt[w]
                  + CNT_W'(w_push[w])
                  - CNT_W'(w_pop[w]);
      end
    end
  end

  // Payload storage is unreachable after reset, so it carries no reset
  always_ff @(posedge clk) begin
    for (int w = 0; w < ISSUE_RATIO; w++) begin
      if (w_push[w])
        r_mem[w][r_wptr[w]] <= decode_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_wis   <= '0;
      r_data  <= '0;
      r_rr    <= '0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_wis   <= w_grant;
      r_data  <= w_head;
      r_rr    <= w_rr_next;
    end else if (ibuf_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign decode_ready = w_ready;
  assign ibuf_valid   = r_valid;
  assign ibuf_wis     = r_wis;
  assign ibuf_data    = r_data;
  assign deq_mask     = w_pop;
  assign empty_mask   = ~w_nonempty;

  always_comb begin
    w_occ = int'(r_valid);
    for (int w = 0; w < ISSUE_RATIO; w++)
      w_occ = w_occ + int'(r_cnt[w]);
  end

  a_no_full_push: assert property (
    @(posedge clk) disable iff (!reset)
    (w_push & w_full) == '0);

  a_deq_onehot: assert property (
    @(posedge clk) disable iff (!reset)
    $onehot0(deq_mask));

  a_occ_bound: assert property (
    @(posedge clk) disable iff (!reset)
    w_occ <= ISSUE_RATIO * DEPTH + 1);

endmodule

// File: tb/tb_vx_ibuffer_scalar_queue.sv
// Directed bench for vx_ibuffer_scalar_queue: reset, ordering,
// backpressure, round-robin, stall hold and full-warp push/pop.
module tb_vx_ibuffer_scalar_queue;

  logic         clk;
  logic         reset;
  logic         decode_valid;
  logic [1:0]   decode_wis;
  logic [127:0] decode_data;
  logic         decode_ready;
  logic         ibuf_valid;
  logic [1:0]   ibuf_wis;
  logic [127:0] ibuf_data;
  logic         ibuf_ready;
  logic [3:0]   deq_mask;
  logic [3:0]   empty_mask;

  int n_vec;
  int n_err;

  vx_ibuffer_scalar_queue #(
    .DATAW(128),
    .ISSUE_RATIO(4),
    .DEPTH(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .decode_valid(decode_valid),
    .decode_wis(decode_wis),
    .decode_data(decode_data),
    .decode_ready(decode_ready),
    .ibuf_valid(ibuf_valid),
    .ibuf_wis(ibuf_wis),
    .ibuf_data(ibuf_data),
    .ibuf_ready(ibuf_ready),
    .deq_mask(deq_mask),
    .empty_mask(empty_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] wis, input logic [127:0] d);
    decode_valid = 1'b1;
    decode_wis   = wis;
    decode_data  = d;
  endtask

  task automatic do_reset();
    reset        = 1'b0;
    decode_valid = 1'b0;
    decode_wis   = '0;
    decode_data  = '0;
    ibuf_ready   = 1'b0;
    tick();
    tick();
    #2 reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [127:0] g;
    g = {4{32'h6000_0002}};
    tick();
    n_vec++;
    if (ibuf_valid !== 1'b0) begin
      n_err++; $display("FAIL rst_valid got %b want 0", ibuf_valid);
    end
    n_vec++;
    if (ibuf_data !== '0 || ibuf_wis !== 2'd0) begin
      n_err++; $display("FAIL rst_out got %h/%0d want 0/0", ibuf_data, ibuf_wis);
    end
    n_vec++;
    if (deq_mask !== 4'b0000 || empty_mask !== 4'b1111) begin
      n_err++; $display("FAIL rst_masks got %b/%b want 0000/1111", deq_mask, empty_mask);
    end
    #2 reset = 1'b1;
    tick();
    push(2'd1, {4{32'h7000_0000}});
    tick();
    decode_data = {4{32'h7000_0001}};
    tick();
    decode_data = {4{32'h7000_0002}};
    tick();
    decode_valid = 1'b0;
    n_vec++;
    if (ibuf_valid !== 1'b1 || empty_mask !== 4'b1101) begin
      n_err++; $display("FAIL rst_preload got %b/%b want 1/1101", ibuf_valid, empty_mask);
    end
    #2 reset = 1'b0;
    #1;
    n_vec++;
    if (ibuf_valid !== 1'b0 || ibuf_data !== '0) begin
      n_err++; $display("FAIL rst_mid_out got %b/%h want 0/0", ibuf_valid, ibuf_data);
    end
    n_vec++;
    if (empty_mask !== 4'b1111) begin
      n_err++; $display("FAIL rst_mid_empty got %b want 1111", empty_mask);
    end
    #2 reset = 1'b1;
    ibuf_ready = 1'b1;
    tick();
    push(2'd2, g);
    tick();
    decode_valid = 1'b0;
    n_vec++;
    if (ibuf_valid !== 1'b0 || deq_mask !== 4'b0100) begin
      n_err++; $display("FAIL rst_lat1 got %b/%b want 0/0100", ibuf_valid, deq_mask);
    end
    tick();
    n_vec++;
    if (ibuf_valid !== 1'b1 || ibuf_wis !== 2'd2 || ibuf_data !== g) begin
      n_err++; $display("FAIL rst_lat2 got %b/%0d/%h want 1/2/%h", ibuf_valid, ibuf_wis, ibuf_data, g);
    end
  endtask

  task automatic test_single_order();
    logic [127:0] a;
    logic [127:0] b;
    a = {4{32'hA000_0001}};
    b = {4{32'hB000_0002}};
    do_reset();
    tick();
    ibuf_ready = 1'b1;
    push(2'd0, a);
    #1;
    n_vec++;
    if (deq_mask !== 4'b0000) begin
      n_err++; $display("FAIL ord_nobypass got %b want 0000", deq_mask);
    end
    tick();
    push(2'd0, b);
    #1;
    n_vec++;
    if (deq_mask !== 4'b0001) begin
      n_err++; $display("FAIL ord_deqA got %b want 0001", deq_mask);
    end
    tick();
    decode_valid = 1'b0;
    n_vec++;
    if (ibuf_valid !== 1'b1 || ibuf_data !== a || ibuf_wis !== 2'd0) begin
      n_err++; $display("FAIL ord_A got %b/%h/%0d want 1/%h/0", ibuf_valid, ibuf_data, ibuf_wis, a);
    end
    #1;
    n_vec++;
    if (deq_mask !== 4'b0001) begin
      n_err++; $display("FAIL ord_deqB got %b want 0001", deq_mask);
    end
    tick();
    n_vec++;
    if (ibuf_valid !== 1'b1 || ibuf_data !== b) begin
      n_err++; $display("FAIL ord_B got %b/%h want 1/%h", ibuf_valid, ibuf_data, b);
    end
    n_vec++;
    if (deq_mask !== 4'b0000) begin
      n_err++; $display("FAIL ord_deq_idle got %b want 0000", deq_mask);
    end
    tick();
    n_vec++;
    if (ibuf_valid !== 1'b0 || empty_mask !== 4'b1111) begin
      n_err++; $display("FAIL ord_drain got %b/%b want 0/1111", ibuf_valid, empty_mask);
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] x [4];
    for (int i = 0; i < 4; i++)
      x[i] = {4{32'hC000_0000 + 32'(i)}};
    do_reset();
    tick();
    for (int i = 0; i < 3; i++) begin
      push(2'd3, x[i]);
      tick();
    end
    push(2'd3, x[3]);
    #1;
    n_vec++;
    if (decode_ready !== 1'b0) begin
      n_err++; $display("FAIL bp_full_ready got %b want 0", decode_ready);
    end
    n_vec++;
    if (ibuf_data !== x[0] || empty_mask !== 4'b0111) begin
      n_err++; $display("FAIL bp_hold got %h/%b want %h/0111", ibuf_data, empty_mask, x[0]);
    end
    decode_valid = 1'b0;
    ibuf_ready   = 1'b1;
    #1;
    n_vec++;
    if (deq_mask !== 4'b1000) begin
      n_err++; $display("FAIL bp_deq got %b want 1000", deq_mask);
    end
    for (int i = 1; i < 3; i++) begin
      tick();
      n_vec++;
      if (ibuf_valid !== 1'b1 || ibuf_data !== x[i] || ibuf_wis !== 2'd3) begin
        n_err++; $display("FAIL bp_drain%0d got %b/%h/%0d want 1/%h/3", i, ibuf_valid, ibuf_data, ibuf_wis, x[i]);
      end
    end
    tick();
    n_vec++;
    if (ibuf_valid !== 1'b0) begin
      n_err++; $display("FAIL bp_end got %b want 0", ibuf_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0]   ew [6];
    logic [127:0] ed [6];
    do_reset();
    tick();
    for (int w = 0; w < 3; w++) begin
      for (int k = 0; k < 2; k++) begin
        push(2'(w), {4{32'hD000_0000 + 32'(w * 16 + k)}});
        tick();
      end
    end
    decode_valid = 1'b0;
    ew[0] = 2'd0; ed[0] = {4{32'hD000_0000}};
    ew[1] = 2'd1; ed[1] = {4{32'hD000_0010}};
    ew[2] = 2'd2; ed[2] = {4{32'hD000_0020}};
    ew[3] = 2'd0; ed[3] = {4{32'hD000_0001}};
    ew[4] = 2'd1; ed[4] = {4{32'hD000_0011}};
    ew[5] = 2'd2; ed[5] = {4{32'hD000_0021}};
    ibuf_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      n_vec++;
      if (ibuf_valid !== 1'b1 || ibuf_wis !== ew[i] || ibuf_data !== ed[i]) begin
        n_err++; $display("FAIL rr_%0d got %b/%0d/%h want 1/%0d/%h", i, ibuf_valid, ibuf_wis, ibuf_data, ew[i], ed[i]);
      end
      tick();
    end
    n_vec++;
    if (ibuf_valid !== 1'b0 || empty_mask !== 4'b1111) begin
      n_err++; $display("FAIL rr_end got %b/%b want 0/1111", ibuf_valid, empty_mask);
    end
  endtask

  task automatic test_stall_hold();
    logic [127:0] d;
    logic [127:0] e;
    d = {4{32'hE000_0002}};
    e = {4{32'hE000_0001}};
    do_reset();
    tick();
    push(2'd2, d);
    tick();
    push(2'd1, e);
    tick();
    decode_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_vec++;
      if (ibuf_valid !== 1'b1 || ibuf_data !== d || ibuf_wis !== 2'd2 || deq_mask !== 4'b0000) begin
        n_err++; $display("FAIL stall_%0d got %b/%h/%0d/%b want 1/%h/2/0000", i, ibuf_valid, ibuf_data, ibuf_wis, deq_mask, d);
      end
      tick();
    end
    ibuf_ready = 1'b1;
    #1;
    n_vec++;
    if (deq_mask !== 4'b0010) begin
      n_err++; $display("FAIL stall_release got %b want 0010", deq_mask);
    end
    tick();
    n_vec++;
    if (ibuf_data !== e || ibuf_wis !== 2'd1) begin
      n_err++; $display("FAIL stall_next got %h/%0d want %h/1", ibuf_data, ibuf_wis, e);
    end
  endtask

  task automatic test_full_push_pop();
    logic [127:0] f [4];
    for (int i = 0; i < 4; i++)
      f[i] = {4{32'hF000_0000 + 32'(i)}};
    do_reset();
    tick();
    for (int i = 0; i < 3; i++) begin
      push(2'd1, f[i]);
      tick();
    end
    ibuf_ready = 1'b1;
    push(2'd1, f[3]);
    #1;
    n_vec++;
    if (decode_ready !== 1'b0 || deq_mask !== 4'b0010) begin
      n_err++; $display("FAIL full_pp got %b/%b want 0/0010", decode_ready, deq_mask);
    end
    tick();
    n_vec++;
    if (decode_ready !== 1'b1 || ibuf_data !== f[1]) begin
      n_err++; $display("FAIL full_retry got %b/%h want 1/%h", decode_ready, ibuf_data, f[1]);
    end
    tick();
    decode_valid = 1'b0;
    n_vec++;
    if (ibuf_data !== f[2] || empty_mask !== 4'b1101) begin
      n_err++; $display("FAIL full_f2 got %h/%b want %h/1101", ibuf_data, empty_mask, f[2]);
    end
    tick();
    n_vec++;
    if (ibuf_valid !== 1'b1 || ibuf_data !== f[3]) begin
      n_err++; $display("FAIL full_f3 got %b/%h want 1/%h", ibuf_valid, ibuf_data, f[3]);
    end
    tick();
    n_vec++;
    if (ibuf_valid !== 1'b0) begin
      n_err++; $display("FAIL full_end got %b want 0", ibuf_valid);
    end
  endtask

  initial begin
    n_vec        = 0;
    n_err        = 0;
    reset        = 1'b0;
    decode_valid = 1'b0;
    decode_wis   = '0;
    decode_data  = '0;
    ibuf_ready   = 1'b0;
    test_reset();
    test_single_order();
    test_backpressure();
    test_round_robin();
    test_stall_hold();
    test_full_push_pop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
